// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer sharing one repeated-addition multiplier
// datapath among N requesters.
module mul_share_ctrl #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   res,
  output logic           busy,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic           ldA,
  output logic           ldB,
  output logic           clrP,
  output logic           ldP,
  output logic           decB,
  input  logic [W-1:0]   p_in,
  input  logic           eqZ
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_ADD,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [W-1:0]    res_q, res_d;
  logic [N-1:0]    own_oh;
  logic [IW-1:0]   pick;
  logic            found;
  int              srch_k;

  // First set request at or after ptr, wrapping past N-1.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    srch_k = 0;
    for (int i = 0; i < N; i++) begin
      srch_k = int'(ptr_q) + i;
      if (srch_k >= N) srch_k = srch_k - N;
      if (!found && req[srch_k[IW-1:0]]) begin
        found = 1'b1;
        pick  = srch_k[IW-1:0];
      end
    end
  end

  assign own_oh = {{(N-1){1'b0}}, 1'b1} << owner_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    res_d   = res_q;
    gnt     = '0;
    done    = '0;
    busy    = 1'b1;
    ldA     = 1'b0;
    ldB     = 1'b0;
    clrP    = 1'b0;
    ldP     = 1'b0;
    decB    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (found) begin
          owner_d = pick;
          ptr_d   = (pick == LAST) ? '0 : pick + 1'b1;
          state_d = S_LDA;
        end
      end
      S_LDA: begin
        ldA     = 1'b1;
        gnt     = own_oh;
        state_d = S_LDB;
      end
      S_LDB: begin
        ldB     = 1'b1;
        clrP    = 1'b1;
        state_d = S_ADD;
      end
      S_ADD: begin
        // Gating on eqZ means b=0 performs no add at all.
        if (!eqZ) begin
          ldP  = 1'b1;
          decB = 1'b1;
        end else begin
          res_d   = p_in;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = own_oh;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      res_q   <= res_d;
    end
  end

  assign res  = res_q;
  assign op_a = busy ? a_in[owner_q*W +: W] : '0;
  assign op_b = busy ? b_in[owner_q*W +: W] : '0;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural
// A/B/P datapath closing the loop.
module tb_mul_share_ctrl;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   res;
  logic           busy;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           ldA, ldB, clrP, ldP, decB;
  logic [W-1:0]   p_in;
  logic           eqZ;

  logic [W-1:0]   dA, dB, dP;

  int n_chk  = 0;
  int n_fail = 0;

  mul_share_ctrl #(.N(N), .W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .a_in (a_in),
    .b_in (b_in),
    .gnt  (gnt),
    .done (done),
    .res  (res),
    .busy (busy),
    .op_a (op_a),
    .op_b (op_b),
    .ldA  (ldA),
    .ldB  (ldB),
    .clrP (clrP),
    .ldP  (ldP),
    .decB (decB),
    .p_in (p_in),
    .eqZ  (eqZ)
  );

  always #5 clk = ~clk;

  // Shared multiplier datapath.
  always @(posedge clk) begin
    if (ldA) dA <= op_a;
    if (ldB) dB <= op_b;
    else if (decB) dB <= dB - 1'b1;
    if (clrP) dP <= '0;
    else if (ldP) dP <= dP + dA;
  end
  assign eqZ  = (dB == '0);
  assign p_in = dP;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    a_in[i*W +: W] = W'(a);
    b_in[i*W +: W] = W'(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_one(input string tag, input int gcyc,
                         input int gbits, input int a,
                         input int b, input int dcyc,
                         input int rres);
    int g_at;
    int d_at;
    int adds;
    g_at = -1;
    d_at = -1;
    adds = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (gnt != '0 && g_at < 0) begin
        g_at = k;
        check({tag, "_gbits"}, 32'(gnt), gbits);
        check({tag, "_ldA"}, 32'(ldA), 1);
        check({tag, "_opa"}, 32'(op_a), a);
      end else if (g_at > 0 && k == g_at + 1) begin
        check({tag, "_ldB_clrP"}, 32'({ldB, clrP}), 3);
        check({tag, "_opb"}, 32'(op_b), b);
      end
      if (ldP) adds++;
      if (done != '0) begin
        d_at = k;
        check({tag, "_dbits"}, 32'(done), gbits);
        check({tag, "_res"}, 32'(res), rres);
        break;
      end
    end
    check({tag, "_gcyc"}, g_at, gcyc);
    check({tag, "_dcyc"}, d_at, dcyc);
    check({tag, "_adds"}, adds, b);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_res"}, 32'(res), 0);
    check({tag, "_strb"}, 32'({ldA, ldB, clrP, ldP, decB}), 0);
    check({tag, "_ops"}, 32'({op_a, op_b}), 0);
  endtask

  initial begin
    int exp_g[5];
    int exp_r[5];
    int ng;
    int nd;
    int d_at;
    int g_last;
    exp_g = '{1, 2, 4, 8, 1};
    exp_r = '{10, 11, 12, 13, 10};
    rst   = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;

    do_reset();
    check_idle("reset");

    set_op(0, 5, 3);
    req = 4'b0001;
    run_one("single", 1, 1, 5, 3, 7, 15);
    req = '0;
    tick();

    set_op(1, 9, 0);
    req = 4'b0010;
    run_one("zero", 1, 2, 9, 0, 4, 0);
    req = '0;
    tick();

    set_op(2, 200, 2);
    req = 4'b0100;
    run_one("ovf", 1, 4, 200, 2, 6, 144);
    req = '0;
    tick();

    // Round-robin with every requester held high.
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, 10 + i, 1);
    req    = 4'b1111;
    ng     = 0;
    nd     = 0;
    g_last = 0;
    for (int k = 1; k <= 60 && nd < 5; k++) begin
      tick();
      if (gnt != '0 && ng < 5) begin
        check($sformatf("rr_g%0d", ng), 32'(gnt), exp_g[ng]);
        check($sformatf("rr_gc%0d", ng), k, 1 + 6 * ng);
        g_last = k;
        ng++;
      end
      if (done != '0 && nd < 5) begin
        check($sformatf("rr_d%0d", nd), 32'(done), exp_g[nd]);
        check($sformatf("rr_lat%0d", nd), k - g_last, 4);
        check($sformatf("rr_r%0d", nd), 32'(res), exp_r[nd]);
        nd++;
      end
    end
    check("rr_ndone", nd, 5);
    req = '0;
    tick();

    // Reset in the middle of ADD.
    do_reset();
    set_op(0, 3, 10);
    req = 4'b0001;
    for (int k = 1; k <= 6; k++) tick();
    check("rstadd_ldP", 32'(ldP), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rstadd");
    set_op(1, 4, 4);
    req = 4'b0011;
    run_one("rst_ptr", 1, 1, 3, 10, 14, 30);
    req = '0;
    tick();

    // Drop req2 mid-operation while req0 arrives.
    do_reset();
    set_op(2, 7, 4);
    req  = 4'b0100;
    d_at = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 4) begin
        check("drop_ldP", 32'(ldP), 1);
        set_op(0, 6, 2);
        req = 4'b0001;
      end
      if (done != '0) begin
        d_at = k;
        check("drop_dbits", 32'(done), 4);
        check("drop_res", 32'(res), 28);
        break;
      end
    end
    check("drop_dcyc", d_at, 8);
    run_one("drop_next", 2, 1, 6, 2, 7, 12);
    req = '0;
    tick();
    check("end_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
